alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester round-robin arbiter that time-shares one 32-bit MIPS32 ALU core (AND/OR/XOR/NOR/ADD/SUB/SLT) between the fetch-side address unit (requester 0) and the execute-stage issue logic (requester 1). It accepts one operation per cycle and registers the result in a single-entry output buffer with a valid/ready handshake and backpressure. Each result carries a requester tag, so the two clients can demultiplex the shared output.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_op  in  3  requester 0 ALU opcode
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- res_valid  out  1  result buffer holds a result
- res_ready  in  1  consumer takes the result this cycle when high with res_valid
- res_tag  out  1  requester index the result belongs to
- res_data  out  WIDTH  ALU result
- res_zero  out  1  res_data == 0
- res_err  out  1  opcode was reserved (111)
- ops_done  out  CNT_W  count of results handed off; wraps modulo 2^CNT_W

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD (wrap, no overflow trap), 101 SUB (A−B, wrap), 110 SLT (signed A<B → 32'd1 else 0), 111 reserved → res_data 0, res_err 1.
- Output buffer is a two-state FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on a simultaneous drain and accept.
  - FULL → EMPTY on drain without accept.
- `slot_free = !res_valid || res_ready`. Same-cycle drain and refill is allowed.
- Grant, priority pointer `prio` (reset 0):
  - Both valid → grant goes to `prio`.
  - One valid → that requester is granted.
- `reqN_ready = slot_free && grant==N`. At most one ready is high per cycle. Ready does not depend on the requester's own valid beyond arbitration.
- On accept:
  - Buffer loads {tag, result, zero, err}.
  - `prio` becomes the non-granted index.
- If nothing is accepted, `prio` holds.
- `ops_done` increments on each `res_valid && res_ready`. It wraps from 0xFFFF to 0.
- Buffer contents are stable while `res_valid && !res_ready`.

## Timing
- Latency: accept in cycle T → res_valid in T+1.
- Throughput: 1 op/cycle while res_ready is held high.
- Reset values: res_valid 0, res_tag 0, res_data 0, res_zero 0, res_err 0, ops_done 0, prio 0. ready outputs are combinational from reset state, so slot is free.
- Reset asserted mid-operation discards the buffered result with no handoff, and ops_done is not incremented.
- Backpressure: while FULL with res_ready low, both readys are low. Requesters must hold valid and operands stable until accepted.
- Simultaneous requests alternate strictly: 0,1,0,1…

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams: ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_RSVD
  - the 3-bit opcode width
- Sub-module `alu_core`: purely combinational. Inputs op, A, B; outputs result, zero, err. Reusable by the single-cycle datapath.
- The arbiter contains the grant logic, the output-buffer FSM, and the counter.

## Test plan
- Reset, then idle:
  - res_valid=0, ops_done=0.
  - req0_ready=1 and req1_ready=0 when only req0 is valid.
- req0 XOR A=0xFFFF0000, B=0x0F0F0F0F with res_ready=1 → next cycle res_data=0xF0F00F0F, tag 0, zero 0, ops_done=1.
- Both valid every cycle, res_ready=1:
  - accepts alternate tags 0,1,0,1.
  - req1 SUB 5−5 → res_data 0, res_zero 1.
  - req0 SLT 0xFFFFFFFF<1 → res_data 1.
- res_ready held low for 3 cycles after a result:
  - res_data and res_tag stay stable.
  - both readys stay 0.
  - on release, the new accept occurs in the same cycle and ops_done advances by exactly 1.
- Opcode 111 → res_err=1, res_data=0. ADD 0xFFFFFFFF+1 → 0, zero 1.
- Preload ops_done to 0xFFFF by 65535 handoffs, then one more → 0x0000. Reset asserted while FULL → res_valid=0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and output-buffer state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

   localparam int ALU_OP_W = 3;

   localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b100;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b101;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'b110;
   localparam logic [ALU_OP_W-1:0] ALU_RSVD = 3'b111;

   // Single-entry result buffer occupancy.
   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS32-style ALU: AND/OR/XOR/NOR/ADD/SUB/SLT, reserved opcode flags err.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all flow control.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic [WIDTH-1:0]    result,
   output logic                zero,
   output logic                err
);

   // Opcode decode; arithmetic wraps, reserved opcode yields zero data with err set.
   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: err    = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, result held in a tagged single-entry buffer.
// Latency: accept in cycle T, res_valid in T+1; one op per cycle when res_ready stays high.
// Backpressure: both readys drop while the buffer is full and res_ready is low; drain+refill same cycle.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [ALU_OP_W-1:0] req0_op,
   input  logic [WIDTH-1:0]    req0_a,
   input  logic [WIDTH-1:0]    req0_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [ALU_OP_W-1:0] req1_op,
   input  logic [WIDTH-1:0]    req1_a,
   input  logic [WIDTH-1:0]    req1_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_tag,
   output logic [WIDTH-1:0]    res_data,
   output logic                res_zero,
   output logic                res_err,
   output logic [CNT_W-1:0]    ops_done
);

   buf_state_t          state;
   logic                prio;
   logic                grant;
   logic                slot_free;
   logic                accept;
   logic [ALU_OP_W-1:0] sel_op;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;
   logic [WIDTH-1:0]    alu_result;
   logic                alu_zero;
   logic                alu_err;

   // Grant: contention goes to the priority pointer, otherwise to whoever is asking.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = prio;
      end
   end

   assign res_valid  = (state == BUF_FULL);
   assign slot_free  = !res_valid || res_ready;
   assign req0_ready = slot_free && !grant;
   assign req1_ready = slot_free && grant;
   assign accept     = grant ? req1_valid && req1_ready : req0_valid && req0_ready;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_alu_core (
      .op     (sel_op),
      .a      (sel_a),
      .b      (sel_b),
      .result (alu_result),
      .zero   (alu_zero),
      .err    (alu_err)
   );

   // Output buffer FSM, priority pointer and handoff counter; buffer holds still while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BUF_EMPTY;
         prio     <= 1'b0;
         res_tag  <= 1'b0;
         res_data <= '0;
         res_zero <= 1'b0;
         res_err  <= 1'b0;
         ops_done <= '0;
      end else begin
         if (res_valid && res_ready) begin
            ops_done <= ops_done + CNT_W'(1);
         end
         if (accept) begin
            res_tag  <= grant;
            res_data <= alu_result;
            res_zero <= alu_zero;
            res_err  <= alu_err;
            prio     <= ~grant;
         end
         case (state)
            BUF_EMPTY: if (accept) state <= BUF_FULL;
            BUF_FULL:  if (res_ready && !accept) state <= BUF_EMPTY;
            default:   state <= BUF_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        res_valid, res_ready, res_tag, res_zero, res_err;
   logic [31:0] res_data;
   logic [15:0] ops_done;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
      .res_data(res_data), .res_zero(res_zero), .res_err(res_err),
      .ops_done(ops_done)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        z;
      logic        e;
   } vec_t;

   typedef struct {
      logic        tag;
      logic [31:0] d;
      logic        z;
      logic        e;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic        mdl_full = 1'b0;
   logic        mdl_prio = 1'b0;
   logic [15:0] exp_ops = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic tag, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      r.tag = tag;
      r.e   = 1'b0;
      case (op)
         3'd0: r.d = a & b;
         3'd1: r.d = a | b;
         3'd2: r.d = a ^ b;
         3'd3: r.d = ~a & ~b;
         3'd4: r.d = a + b;
         3'd5: r.d = a + ~b + 32'd1;
         3'd6: r.d = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         default: begin r.d = 32'd0; r.e = 1'b1; end
      endcase
      r.z = (r.d == 32'd0);
      return r;
   endfunction

   // One clock: check pre-edge handshakes against the model, update scoreboard, then check post-edge state.
   task automatic step();
      logic g, free, acc0, acc1, rst;
      exp_t x;
      #1;
      rst = reset;
      if (!rst) begin
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               x = sb.pop_front();
               chk("sb_tag", {31'd0, res_tag}, {31'd0, x.tag});
               chk("sb_data", res_data, x.d);
               chk("sb_zero", {31'd0, res_zero}, {31'd0, x.z});
               chk("sb_err", {31'd0, res_err}, {31'd0, x.e});
            end
            exp_ops = exp_ops + 16'd1;
         end
         free = !mdl_full || res_ready;
         if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? mdl_prio : req1_valid;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, free && !g});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, free && g});
         end
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         if (acc0) begin sb.push_back(model(1'b0, req0_op, req0_a, req0_b)); mdl_prio = 1'b1; end
         if (acc1) begin sb.push_back(model(1'b1, req1_op, req1_a, req1_b)); mdl_prio = 1'b0; end
         if (acc0 || acc1) mdl_full = 1'b1;
         else if (res_ready) mdl_full = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         mdl_full = 1'b0;
         mdl_prio = 1'b0;
         exp_ops  = 16'd0;
         sb.delete();
      end
      chk("res_valid", {31'd0, res_valid}, {31'd0, mdl_full});
      chk("ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
   endtask

   vec_t        vecs[12];
   logic        prev_tag, have_prev, hold_tag;
   logic [31:0] hold_data;
   logic [15:0] base_ops;

   initial begin
      vecs[0]  = '{3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0};
      vecs[1]  = '{3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
      vecs[2]  = '{3'd1, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0};
      vecs[3]  = '{3'd3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[5]  = '{3'd5, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
      vecs[6]  = '{3'd5, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[7]  = '{3'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      vecs[8]  = '{3'd6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
      vecs[9]  = '{3'd6, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
      vecs[10] = '{3'd7, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b1};
      vecs[11] = '{3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};

      reset = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
      step(); step();
      reset = 1'b0;
      chk("rst_tag", {31'd0, res_tag}, 32'd0);
      chk("rst_data", res_data, 32'd0);
      chk("rst_zero", {31'd0, res_zero}, 32'd0);
      chk("rst_err", {31'd0, res_err}, 32'd0);

      // Idle then a lone req0 XOR.
      req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
      #1;
      chk("idle_rdy0", {31'd0, req0_ready}, 32'd1);
      chk("idle_rdy1", {31'd0, req1_ready}, 32'd0);
      step();
      chk("xor_data", res_data, 32'hF0F00F0F);
      chk("xor_tag", {31'd0, res_tag}, 32'd0);
      chk("xor_zero", {31'd0, res_zero}, 32'd0);
      req0_valid = 1'b0;
      step();
      chk("xor_ops", {16'd0, ops_done}, 32'd1);

      // Table of single operations through requester 0.
      for (int i = 0; i < 12; i++) begin
         req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
         step();
         chk("vec_valid", {31'd0, res_valid}, 32'd1);
         chk("vec_tag", {31'd0, res_tag}, 32'd0);
         chk("vec_data", res_data, vecs[i].d);
         chk("vec_zero", {31'd0, res_zero}, {31'd0, vecs[i].z});
         chk("vec_err", {31'd0, res_err}, {31'd0, vecs[i].e});
         req0_valid = 1'b0;
         step();
      end

      // Contention: strict alternation.
      req0_valid = 1'b1; req0_op = 3'd6; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
      req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'd5;        req1_b = 32'd5;
      have_prev = 1'b0; prev_tag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (have_prev) chk("alt_tag", {31'd0, res_tag}, {31'd0, ~prev_tag});
         chk("alt_data", res_data, res_tag ? 32'd0 : 32'd1);
         chk("alt_zero", {31'd0, res_zero}, {31'd0, res_tag});
         prev_tag = res_tag; have_prev = 1'b1;
      end

      // Stall with res_ready low for three cycles.
      res_ready = 1'b0;
      hold_tag = res_tag; hold_data = res_data;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_rdy0", {31'd0, req0_ready}, 32'd0);
         chk("stall_rdy1", {31'd0, req1_ready}, 32'd0);
         step();
         chk("stall_tag", {31'd0, res_tag}, {31'd0, hold_tag});
         chk("stall_data", res_data, hold_data);
      end
      res_ready = 1'b1;
      #1;
      chk("release_rdy", {31'd0, req0_ready | req1_ready}, 32'd1);
      base_ops = exp_ops;
      step();
      chk("release_ops", {16'd0, ops_done}, {16'd0, base_ops + 16'd1});
      chk("release_tag", {31'd0, res_tag}, {31'd0, ~hold_tag});

      // Reset while full discards the result.
      res_ready = 1'b0;
      step();
      chk("full_before_rst", {31'd0, res_valid}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_full_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_full_ops", {16'd0, ops_done}, 32'd0);

      // Counter wrap: 65535 handoffs, then one more.
      req1_valid = 1'b0; res_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd1; req0_b = 32'd2;
      for (int i = 0; i < 65536; i++) step();
      chk("wrap_pre", {16'd0, ops_done}, 32'h0000FFFF);
      req0_valid = 1'b0;
      step();
      chk("wrap_post", {16'd0, ops_done}, 32'd0);
      chk("wrap_empty", {31'd0, res_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
